hci_l2_core_req_buffer: RTL and testbench

Per-initiator decoupling stage placed directly upstream of one core-side channel of the L2 log interconnect (one instance per CH0/CH1 port that needs buffering, e.g. DMA or accelerator masters).
- Buffers up to DEPTH requests from the master and replays them to the interconnect under req/gnt.
- Collects the interconnect's fixed one-cycle-after-grant responses into a response FIFO drained by the master under r_valid/r_ready.
- A credit check guarantees the response FIFO never overflows, because the interconnect cannot be back-pressured on responses.

---
 rtl/hci_l2_core_req_buffer_pkg.sv | 32 +++
 rtl/hci_l2_sync_fifo.sv | 48 ++++
 rtl/hci_l2_core_req_buffer.sv | 135 +++++++++++++
 tb/tb_hci_l2_core_req_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hci_l2_core_req_buffer_pkg.sv
// Shared types and width helpers for the L2 core-side request buffer.
//   hci_l2_req_payload_t : request payload at the default widths
//                          (AW=32, DW=32, BW=8, UW=1).
//   req_payload_w()      : packed request payload width for any parameter set.
//   resp_payload_w()     : packed response payload width for any parameter set.
package hci_l2_core_req_buffer_pkg;

    localparam int unsigned HCI_AW = 32;
    localparam int unsigned HCI_DW = 32;
    localparam int unsigned HCI_BW = 8;
    localparam int unsigned HCI_UW = 1;

    // Field order matches the packed FIFO word used by the buffer:
    // {add, wen, data, be, user}.
    typedef struct packed {
        logic [HCI_AW-1:0]        add;
        logic                     wen;
        logic [HCI_DW-1:0]        data;
        logic [HCI_DW/HCI_BW-1:0] be;
        logic [HCI_UW-1:0]        user;
    } hci_l2_req_payload_t;

    function automatic int unsigned req_payload_w(int unsigned aw, int unsigned dw,
                                                  int unsigned bw, int unsigned uw);
        return aw + 1 + dw + dw / bw + uw;
    endfunction

    function automatic int unsigned resp_payload_w(int unsigned dw, int unsigned uw);
        return dw + uw;
    endfunction

endpackage

// File: rtl/hci_l2_sync_fifo.sv
// Single-clock FIFO with registered storage and no fall-through.
//   push_i/wdata_i : write side; the caller must not push while full
//                    unless it pops in the same cycle.
//   pop_i/rdata_o  : read side; rdata_o shows the head entry and reads 0
//                    while empty.
//   full_o/empty_o : derived from the pointer compare (log2 index + wrap bit).
//   count_o        : current number of entries.
module hci_l2_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      push_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic                      pop_i,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW:0]           wptr_q, rptr_q;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = empty_o ? '0 : mem[rptr_q[PW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + (PW+1)'(1);
            if (pop_i)  rptr_q <= rptr_q + (PW+1)'(1);
        end
    end

    // Storage needs no reset: reads are masked by empty_o.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[wptr_q[PW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/hci_l2_core_req_buffer.sv
// Decoupling stage in front of one core-side L2 interconnect channel.
// Requests from the master (in_*) are queued and replayed to the
// interconnect (out_*) under req/gnt. The interconnect answers exactly one
// cycle after each grant, cannot be stalled, and those answers are queued
// for the master (in_r_*). Issue is gated by a credit check so the response
// queue always has room for every outstanding answer.
//   in_req_i/in_gnt_o     : master request handshake, payload in_add/wen/data/be/user
//   in_r_valid_o/ready_i  : response to master, in_r_data_o/in_r_user_o
//   out_req_o/out_gnt_i   : request to interconnect, payload out_add/wen/data/be/user
//   out_r_valid_i         : interconnect response, out_r_data_i/out_r_user_i
//   err_o                 : sticky, set on an unexpected or overflowing response
module hci_l2_core_req_buffer
    import hci_l2_core_req_buffer_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned BW         = 8,
    parameter int unsigned UW         = 1,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_req_i,
    output logic                 in_gnt_o,
    input  logic [AW-1:0]        in_add_i,
    input  logic                 in_wen_i,
    input  logic [DW-1:0]        in_data_i,
    input  logic [DW/BW-1:0]     in_be_i,
    input  logic [UW-1:0]        in_user_i,
    output logic                 in_r_valid_o,
    input  logic                 in_r_ready_i,
    output logic [DW-1:0]        in_r_data_o,
    output logic [UW-1:0]        in_r_user_o,
    output logic                 out_req_o,
    input  logic                 out_gnt_i,
    output logic [AW-1:0]        out_add_o,
    output logic                 out_wen_o,
    output logic [DW-1:0]        out_data_o,
    output logic [DW/BW-1:0]     out_be_o,
    output logic [UW-1:0]        out_user_o,
    input  logic                 out_r_valid_i,
    input  logic [DW-1:0]        out_r_data_i,
    input  logic [UW-1:0]        out_r_user_i,
    output logic                 err_o
);

    localparam int unsigned REQ_W  = req_payload_w(AW, DW, BW, UW);
    localparam int unsigned RESP_W = resp_payload_w(DW, UW);
    localparam int unsigned CNT_W  = $clog2(RESP_DEPTH) + 1;
    localparam int unsigned CRED_W = CNT_W + 1;

    logic [REQ_W-1:0]        req_wdata, req_rdata;
    logic                    req_push, req_pop, req_full, req_empty;
    logic [$clog2(DEPTH):0]  req_cnt_unused;

    logic [RESP_W-1:0]       resp_rdata;
    logic                    resp_push, resp_pop, resp_full, resp_empty;
    logic [CNT_W-1:0]        resp_cnt;

    logic                    inflight_q;
    logic                    err_q;
    logic [CRED_W-1:0]       credit_used;

    // ---------------- request path ----------------
    // Grant depends only on fullness, so there is no in_req -> in_gnt path.
    assign in_gnt_o  = !req_full;
    assign req_push  = in_req_i & in_gnt_o;
    assign req_wdata = {in_add_i, in_wen_i, in_data_i, in_be_i, in_user_i};

    hci_l2_sync_fifo #(
        .DATA_WIDTH (REQ_W),
        .DEPTH      (DEPTH)
    ) i_req_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_push),
        .wdata_i (req_wdata),
        .pop_i   (req_pop),
        .rdata_o (req_rdata),
        .full_o  (req_full),
        .empty_o (req_empty),
        .count_o (req_cnt_unused)
    );

    assign {out_add_o, out_wen_o, out_data_o, out_be_o, out_user_o} = req_rdata;

    // Every entry already in the response queue plus the one answer that may
    // still be on its way uses a slot. Once raised, out_req_o stays up: the
    // queue only drains and inflight only clears while we wait for a grant.
    assign credit_used = CRED_W'(resp_cnt) + CRED_W'(inflight_q);
    assign out_req_o   = !req_empty && (credit_used < CRED_W'(RESP_DEPTH));
    assign req_pop     = out_req_o & out_gnt_i;

    // The answer comes exactly one cycle after a grant, so one flag is enough.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) inflight_q <= 1'b0;
        else         inflight_q <= req_pop;
    end

    // ---------------- response path ----------------
    // Writes also answer; that answer is forwarded as the write ack.
    assign resp_pop  = in_r_valid_o & in_r_ready_i;
    assign resp_push = out_r_valid_i & inflight_q & (!resp_full | resp_pop);

    hci_l2_sync_fifo #(
        .DATA_WIDTH (RESP_W),
        .DEPTH      (RESP_DEPTH)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resp_push),
        .wdata_i ({out_r_data_i, out_r_user_i}),
        .pop_i   (resp_pop),
        .rdata_o (resp_rdata),
        .full_o  (resp_full),
        .empty_o (resp_empty),
        .count_o (resp_cnt)
    );

    assign in_r_valid_o               = !resp_empty;
    assign {in_r_data_o, in_r_user_o} = resp_rdata;

    // Unexpected or overflowing answers are dropped and flagged until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (out_r_valid_i && (!inflight_q || (resp_full && !resp_pop))) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_hci_l2_core_req_buffer.sv
// Scoreboard bench for hci_l2_core_req_buffer. Accepted requests push the
// expected interconnect payload and the expected master response; monitors
// pop and compare when the DUT issues a request or delivers a response.
// The interconnect model answers one cycle after each grant with
// data = add ^ 32'hDEADAEEF and user = add[2].
module tb_hci_l2_core_req_buffer;

    localparam int AW = 32, DW = 32, BW = 8, UW = 1;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            in_req_i, in_wen_i, in_r_ready_i, out_gnt_i, out_r_valid_i;
    logic [AW-1:0]   in_add_i;
    logic [DW-1:0]   in_data_i, out_r_data_i;
    logic [DW/BW-1:0] in_be_i;
    logic [UW-1:0]   in_user_i, out_r_user_i;
    logic            in_gnt_o, in_r_valid_o, out_req_o, out_wen_o, err_o;
    logic [DW-1:0]   in_r_data_o, out_data_o;
    logic [UW-1:0]   in_r_user_o, out_user_o;
    logic [AW-1:0]   out_add_o;
    logic [DW/BW-1:0] out_be_o;

    hci_l2_core_req_buffer #(
        .AW(AW), .DW(DW), .BW(BW), .UW(UW), .DEPTH(4), .RESP_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_add_i(in_add_i),
        .in_wen_i(in_wen_i), .in_data_i(in_data_i), .in_be_i(in_be_i),
        .in_user_i(in_user_i), .in_r_valid_o(in_r_valid_o),
        .in_r_ready_i(in_r_ready_i), .in_r_data_o(in_r_data_o),
        .in_r_user_o(in_r_user_o), .out_req_o(out_req_o), .out_gnt_i(out_gnt_i),
        .out_add_o(out_add_o), .out_wen_o(out_wen_o), .out_data_o(out_data_o),
        .out_be_o(out_be_o), .out_user_o(out_user_o),
        .out_r_valid_i(out_r_valid_i), .out_r_data_i(out_r_data_i),
        .out_r_user_i(out_r_user_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef logic [69:0] req_t;   // {add, wen, data, be, user}
    typedef logic [32:0] resp_t;  // {data, user}

    req_t  exp_req[$];
    resp_t exp_resp[$];
    int    checks = 0, errors = 0;
    int    cyc = 0, fire_cnt = 0, pop_cnt = 0;
    int    acc_cyc = 0, fire_cyc = 0, rv_rise_cyc = 0;
    logic  rv_prev = 1'b0, pend = 1'b0, inject = 1'b0;
    logic [AW-1:0] resp_add = '0;

    function automatic resp_t model(input logic [AW-1:0] a);
        return {a ^ 32'hDEADAEEF, a[2]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitors sample 1 time unit before each rising edge.
    always @(negedge clk) begin
        #4;
        if (rst_ni) begin
            if (out_req_o && out_gnt_i) begin
                fire_cnt++;
                fire_cyc = cyc;
                pend     = 1'b1;
                resp_add = out_add_o;
                if (exp_req.size() == 0) chk("issue_unexpected", 1, 0);
                else chk("issue_payload",
                         {out_add_o, out_wen_o, out_data_o, out_be_o, out_user_o},
                         exp_req.pop_front());
            end
            if (in_r_valid_o && in_r_ready_i) begin
                pop_cnt++;
                if (exp_resp.size() == 0) chk("resp_unexpected", 1, 0);
                else chk("resp_payload", {in_r_data_o, in_r_user_o}, exp_resp.pop_front());
            end
            if (in_req_i && in_gnt_o) begin
                acc_cyc = cyc;
                exp_req.push_back({in_add_i, in_wen_i, in_data_i, in_be_i, in_user_i});
                exp_resp.push_back(model(in_add_i));
            end
            if (in_r_valid_o && !rv_prev) rv_rise_cyc = cyc;
            rv_prev = in_r_valid_o;
        end
    end

    // Interconnect model: answer in the cycle after a grant, or a spurious
    // answer when requested by the stimulus.
    always @(negedge clk) begin
        out_r_valid_i = pend | inject;
        {out_r_data_i, out_r_user_i} = pend ? model(resp_add) : 33'h0_5A5A_5A5A;
        pend   = 1'b0;
        inject = 1'b0;
    end

    task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, input logic u);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        in_req_i = 1'b1; in_add_i = a; in_wen_i = w; in_data_i = d; in_be_i = b; in_user_i = u;
        for (int k = 0; k < 50; k++) begin
            #4;
            if (in_gnt_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drop_req();
        @(negedge clk);
        in_req_i = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #4;
            if (exp_req.size() == 0 && exp_resp.size() == 0 && !in_r_valid_o && !out_req_o) begin
                ok = 1'b1; break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [5:0] g;
        int f0, p0, first_pop, regain;
        rst_ni = 1'b0; in_req_i = 0; in_wen_i = 0; in_add_i = '0; in_data_i = '0;
        in_be_i = '0; in_user_i = '0; in_r_ready_i = 0; out_gnt_i = 0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk); #4;
        chk("rst_in_gnt", in_gnt_o, 1);
        chk("rst_out_req", out_req_o, 0);
        chk("rst_r_valid", in_r_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_out_add", out_add_o, 0);
        chk("rst_r_data", in_r_data_o, 0);

        // Single read: out_req one cycle after accept, response three cycles after.
        out_gnt_i = 1; in_r_ready_i = 1;
        send(32'h1000, 1'b1, 32'h0, 4'hF, 1'b0);
        drop_req();
        wait_idle();
        chk("rd_issue_lat", fire_cyc - acc_cyc, 1);
        chk("rd_resp_lat", rv_rise_cyc - acc_cyc, 3);
        chk("rd_err", err_o, 0);

        // Fill with no grant: four accepts, then back-pressure.
        @(negedge clk);
        out_gnt_i = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            in_req_i = 1; in_wen_i = 1; in_add_i = 32'h3000 + 32'(i * 4);
            in_data_i = '0; in_be_i = 4'hF; in_user_i = 0;
            #4; g[i] = in_gnt_o;
        end
        chk("fill_gnt", g, 6'b001111);
        chk("fill_out_req", out_req_o, 1);
        chk("fill_head_stable", out_add_o, 32'h3000);
        @(negedge clk);
        in_req_i = 0; out_gnt_i = 1;
        first_pop = -1; regain = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #4;
            if (first_pop >= 0 && regain < 0 && in_gnt_o) regain = cyc;
            if (first_pop < 0 && out_req_o && out_gnt_i) first_pop = cyc;
        end
        chk("fill_regain", regain - first_pop, 1);
        wait_idle();

        // Credit stall: master not draining responses.
        @(negedge clk);
        in_r_ready_i = 0; out_gnt_i = 1; f0 = fire_cnt;
        for (int i = 0; i < 6; i++) send(32'h4000 + 32'(i * 4), 1'b1, 32'h0, 4'hF, 1'b0);
        drop_req();
        repeat (12) @(negedge clk);
        #4;
        chk("credit_grants", fire_cnt - f0, 4);
        chk("credit_out_req", out_req_o, 0);
        @(negedge clk); in_r_ready_i = 1;
        @(negedge clk); in_r_ready_i = 0;
        repeat (12) @(negedge clk);
        #4;
        chk("credit_one_more", fire_cnt - f0, 5);
        chk("credit_out_req2", out_req_o, 0);
        @(negedge clk); in_r_ready_i = 1;
        wait_idle();
        chk("credit_total", fire_cnt - f0, 6);

        // Write ack.
        p0 = pop_cnt;
        send(32'h2000, 1'b0, 32'hCAFEF00D, 4'b0011, 1'b1);
        drop_req();
        wait_idle();
        chk("wr_ack_count", pop_cnt - p0, 1);

        // Spurious response.
        chk("spur_err_before", err_o, 0);
        @(negedge clk); #2; inject = 1'b1;
        @(negedge clk); #4;
        chk("spur_err_not_yet", err_o, 0);
        @(negedge clk); #4;
        chk("spur_err_set", err_o, 1);
        chk("spur_no_resp", in_r_valid_o, 0);
        repeat (5) @(negedge clk);
        #4;
        chk("spur_err_sticky", err_o, 1);

        // Reset with traffic queued on both sides.
        @(negedge clk);
        in_r_ready_i = 0; out_gnt_i = 1;
        send(32'h5000, 1'b1, 32'h0, 4'hF, 1'b0);
        send(32'h5004, 1'b1, 32'h0, 4'hF, 1'b0);
        drop_req();
        repeat (5) @(negedge clk);
        out_gnt_i = 0;
        send(32'h6000, 1'b1, 32'h0, 4'hF, 1'b0);
        send(32'h6004, 1'b1, 32'h0, 4'hF, 1'b0);
        send(32'h6008, 1'b1, 32'h0, 4'hF, 1'b0);
        drop_req();
        #4;
        chk("pre_rst_r_valid", in_r_valid_o, 1);
        chk("pre_rst_out_req", out_req_o, 1);
        @(negedge clk); #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_in_gnt", in_gnt_o, 1);
        chk("arst_out_req", out_req_o, 0);
        chk("arst_r_valid", in_r_valid_o, 0);
        chk("arst_err", err_o, 0);
        chk("arst_out_add", out_add_o, 0);
        chk("arst_r_data", in_r_data_o, 0);
        exp_req.delete(); exp_resp.delete();
        rv_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        out_gnt_i = 1; in_r_ready_i = 1;
        p0 = pop_cnt;
        send(32'h7008, 1'b1, 32'h0, 4'hF, 1'b0);
        drop_req();
        wait_idle();
        chk("post_rst_resp", pop_cnt - p0, 1);
        chk("post_rst_err", err_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
